// File: rtl/mult_mat_pkg.sv
// Shared definitions for mult_mat and its operand loader carga_matrices.
// Holds element/matrix widths, the loader state enum and a slice helper.
package mult_mat_pkg;

    localparam int ELEM_W = 3;
    localparam int N_ELEM = 4;
    localparam int MAT_W  = ELEM_W * N_ELEM;
    localparam int CNT_W  = $clog2(N_ELEM);

    typedef logic [ELEM_W-1:0] elem_t;
    typedef logic [MAT_W-1:0]  mat_t;
    typedef logic [CNT_W-1:0]  cnt_t;

    typedef enum logic [2:0] {
        LOAD_A,
        LOAD_B,
        EN,
        HOLD,
        DONE
    } state_t;

    // LSB position of element k inside a packed operand word.
    function automatic int elem_lsb(cnt_t k);
        return int'(k) * ELEM_W;
    endfunction

endpackage

// File: rtl/carga_matrices_if.sv
// Element stream into the matrix loader: one element per accepted cycle.
// Ports: dato_in (element), dato_valid (source offers), dato_ready (loader accepts).
interface carga_matrices_if;

    mult_mat_pkg::elem_t dato_in;
    logic                dato_valid;
    logic                dato_ready;

    modport master (
        output dato_in,
        output dato_valid,
        input  dato_ready
    );

    modport slave (
        input  dato_in,
        input  dato_valid,
        output dato_ready
    );

endinterface

// File: rtl/carga_contador.sv
// Loadable down-counter with terminal-count flag (count == 0).
// Ports: clk, rst (sync high), load/load_val, dec (step down), tc.
module carga_contador #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         tc
);

    logic [W-1:0] count;

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign tc = (count == '0);

endmodule

// File: rtl/carga_matrices.sv
// Loader for mult_mat: packs 4+4 streamed elements into matriz_A/B, then
// pulses clk_enable for EN_CYCLES, holds HOLD_CYCLES, pulses listo.
// Ports: clk, rst (sync high), stream (slave), matriz_A/B, clk_enable,
// ocupado, listo, error. Optional macro CARGA_TIMEOUT_EN adds TIMEOUT abort.
module carga_matrices
    import mult_mat_pkg::*;
#(
    parameter int EN_CYCLES   = 2,
    parameter int HOLD_CYCLES = 1
`ifdef CARGA_TIMEOUT_EN
    ,
    parameter int TIMEOUT     = 255
`endif
) (
    input  logic              clk,
    input  logic              rst,
    carga_matrices_if.slave   stream,
    output mat_t              matriz_A,
    output mat_t              matriz_B,
    output logic              clk_enable,
    output logic              ocupado,
    output logic              listo,
    output logic              error
);

    localparam cnt_t LAST = cnt_t'(N_ELEM - 1);

    state_t     state, state_nx;
    cnt_t       cnt;
    mat_t       work_a, work_b;
    logic       xfer, last;
    logic       win_load, win_dec, win_tc;
    logic [7:0] win_val;
    logic       fire;

    assign stream.dato_ready = (state == LOAD_A) || (state == LOAD_B);
    assign xfer       = stream.dato_valid && stream.dato_ready;
    assign last       = xfer && (cnt == LAST);
    assign clk_enable = (state == EN);
    assign ocupado    = (state == EN) || (state == HOLD);
    assign listo      = (state == DONE);

`ifdef CARGA_TIMEOUT_EN
    logic armed, to_tc, error_q;

    // Idle tracking only while a pair is partially loaded.
    assign armed = ((state == LOAD_A) && (cnt != '0)) || (state == LOAD_B);
    assign fire  = armed && !xfer && to_tc;

    carga_contador #(.W(8)) u_timeout (
        .clk      (clk),
        .rst      (rst),
        .load     (xfer || !armed),
        .load_val (8'(TIMEOUT - 1)),
        .dec      (armed && !xfer),
        .tc       (to_tc)
    );

    always_ff @(posedge clk) begin
        if (rst) error_q <= 1'b0;
        else     error_q <= fire;
    end

    assign error = error_q;
`else
    assign fire  = 1'b0;
    assign error = 1'b0;
`endif

    carga_contador #(.W(8)) u_window (
        .clk      (clk),
        .rst      (rst),
        .load     (win_load),
        .load_val (win_val),
        .dec      (win_dec),
        .tc       (win_tc)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= LOAD_A;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        win_load = 1'b0;
        win_val  = '0;
        win_dec  = 1'b0;
        unique case (state)
            LOAD_A: begin
                if (last) state_nx = LOAD_B;
            end
            LOAD_B: begin
                if (last) begin
                    state_nx = EN;
                    win_load = 1'b1;
                    win_val  = 8'(EN_CYCLES - 1);
                end
            end
            EN: begin
                if (win_tc) begin
                    if (HOLD_CYCLES == 0) begin
                        state_nx = DONE;
                    end else begin
                        state_nx = HOLD;
                        win_load = 1'b1;
                        win_val  = 8'(HOLD_CYCLES - 1);
                    end
                end else begin
                    win_dec = 1'b1;
                end
            end
            HOLD: begin
                if (win_tc) state_nx = DONE;
                else        win_dec  = 1'b1;
            end
            DONE:    state_nx = LOAD_A;
            default: state_nx = LOAD_A;
        endcase
        if (fire) state_nx = LOAD_A;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt      <= '0;
            work_a   <= '0;
            work_b   <= '0;
            matriz_A <= '0;
            matriz_B <= '0;
        end else if (fire) begin
            cnt    <= '0;
            work_a <= '0;
            work_b <= '0;
        end else if (xfer) begin
            if (state == LOAD_A) begin
                work_a[elem_lsb(cnt) +: ELEM_W] <= stream.dato_in;
            end else begin
                work_b[elem_lsb(cnt) +: ELEM_W] <= stream.dato_in;
            end
            cnt <= (cnt == LAST) ? '0 : cnt + cnt_t'(1);
            // Last B element bypasses work_b so both words issue together.
            if (state == LOAD_B && cnt == LAST) begin
                matriz_A <= work_a;
                matriz_B <= {stream.dato_in, work_b[MAT_W-ELEM_W-1:0]};
            end
        end
    end

endmodule
